// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the shift-and-add multiplier: Hack ALU control words,
// datapath widths and the sequencer state encoding.
package alu_mul_sequencer_pkg;

  localparam int ALU_W = 16;

  // Control word order is {zx, nx, zy, ny, f, no}
  localparam logic [5:0] ALU_CTRL_ADD    = 6'b000010;
  localparam logic [5:0] ALU_CTRL_PASS_X = 6'b001100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_DBL  = 3'd2,
    S_FLAG = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Combinational 16-bit Hack ALU: zx/nx/zy/ny input conditioning, f selects
// add or and, no inverts the result; zr/ng describe the final output.
module alu_mul_sequencer_alu
  import alu_mul_sequencer_pkg::*;
(
  input  logic [ALU_W-1:0] x,
  input  logic [ALU_W-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [ALU_W-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [ALU_W-1:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = ctrl[5] ? '0 : x;
    x_n   = ctrl[4] ? ~x_z : x_z;
    y_z   = ctrl[3] ? '0 : y;
    y_n   = ctrl[2] ? ~y_z : y_z;
    f_out = ctrl[1] ? (x_n + y_n) : (x_n & y_n);
    out   = ctrl[0] ? ~f_out : f_out;
    zr    = (out == '0);
    ng    = out[ALU_W-1];
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 16x16 -> low-16 multiplier that sequences one Hack ALU through
// ADD/DBL pairs. Define MUL_EARLY_EXIT_EN to stop once the multiplier is exhausted.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_prod,
  output logic             resp_zr,
  output logic             resp_ng,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Requests are taken only in IDLE; a response is held until resp_ready.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, mcand_q, mplr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [5:0]       alu_ctrl;
  logic             alu_zr, alu_ng;

  alu_mul_sequencer_alu u_alu (
    .x    (alu_x),
    .y    (alu_y),
    .ctrl (alu_ctrl),
    .out  (alu_out),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  always_comb begin
    state_d  = state_q;
    alu_x    = acc_q;
    alu_y    = mcand_q;
    alu_ctrl = ALU_CTRL_PASS_X;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
`ifdef MUL_EARLY_EXIT_EN
          state_d = (req_b == '0) ? S_FLAG : S_ADD;
`else
          state_d = S_ADD;
`endif
        end
      end
      S_ADD: begin
        alu_ctrl = ALU_CTRL_ADD;
        state_d  = S_DBL;
      end
      S_DBL: begin
        alu_x    = mcand_q;
        alu_ctrl = ALU_CTRL_ADD;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FLAG;
`ifdef MUL_EARLY_EXIT_EN
        else if ((mplr_q >> 1) == '0) state_d = S_FLAG;
`endif
        else state_d = S_ADD;
      end
      S_FLAG: state_d = S_DONE;
      S_DONE: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplr_q     <= '0;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_prod  <= '0;
      resp_zr    <= 1'b0;
      resp_ng    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            acc_q   <= '0;
            mcand_q <= req_a;
            mplr_q  <= req_b;
            cnt_q   <= '0;
          end
        end
        S_ADD: if (mplr_q[0]) acc_q <= alu_out;
        S_DBL: begin
          mcand_q <= alu_out;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
        end
        S_FLAG: begin
          resp_prod  <= alu_out;
          resp_zr    <= alu_zr;
          resp_ng    <= alu_ng;
          resp_valid <= 1'b1;
        end
        S_DONE: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random checks of alu_mul_sequencer: products, flags, latency,
// response back-pressure, mid-operation reset. Honours MUL_EARLY_EXIT_EN.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_prod;
  logic        resp_zr, resp_ng, busy;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  alu_mul_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_prod  (resp_prod),
    .resp_zr    (resp_zr),
    .resp_ng    (resp_ng),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int exp_latency(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int k;
    if (b == 16'h0) return 1;
    k = 0;
    for (int i = 0; i < 16; i++) if (b[i]) k = i;
    return 2 * (k + 1) + 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    return p[15:0];
  endfunction

  // Presents one request at a negedge, returns edges from accept to resp_valid.
  task automatic issue_and_wait(input logic [15:0] a, input logic [15:0] b, output int edges);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 16'($urandom_range(0, 65535));
    req_b = 16'($urandom_range(0, 65535));
    edges = 0;
    while (resp_valid !== 1'b1 && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (resp_valid !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout a=%h b=%h: resp_valid never rose within %0d edges", a, b, edges);
    end
  endtask

  task automatic run_vector(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ep;
    int edges;
    ep = ref_mul(a, b);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_before a=%h b=%h: got %b want 1", a, b, req_ready);
    end
    issue_and_wait(a, b, edges);
    n_tests++;
    if (resp_prod !== ep) begin
      n_fail++;
      $display("FAIL prod a=%h b=%h: got %h want %h", a, b, resp_prod, ep);
    end
    n_tests++;
    if (resp_zr !== (ep == 16'h0) || resp_ng !== ep[15]) begin
      n_fail++;
      $display("FAIL flags a=%h b=%h: got zr=%b ng=%b want zr=%b ng=%b",
               a, b, resp_zr, resp_ng, (ep == 16'h0), ep[15]);
    end
    n_tests++;
    if (edges != exp_latency(b)) begin
      n_fail++;
      $display("FAIL latency a=%h b=%h: got %0d want %0d", a, b, edges, exp_latency(b));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release a=%h b=%h: got valid=%b ready=%b busy=%b want 0 1 0",
               a, b, resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || resp_prod !== 16'h0 || resp_zr !== 1'b0 ||
        resp_ng !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b prod=%h zr=%b ng=%b busy=%b ready=%b state=%0d want 0 0000 0 0 0 1 0",
               resp_valid, resp_prod, resp_zr, resp_ng, busy, req_ready, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_vector(16'h0003, 16'h0005);
    run_vector(16'hFFFE, 16'h0007);
    run_vector(16'h0100, 16'h0100);
    run_vector(16'h1234, 16'h0000);
    run_vector(16'hFFFF, 16'hFFFF);
    run_vector(16'h8000, 16'h0001);
    run_vector(16'h0007, 16'h8000);
  endtask

  task automatic test_stall();
    int edges;
    issue_and_wait(16'h0012, 16'h0034, edges);
    req_valid = 1'b1;
    req_a = 16'h0002;
    req_b = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (resp_valid !== 1'b1 || resp_prod !== 16'h03A8 || req_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d: got valid=%b prod=%h ready=%b busy=%b want 1 03a8 0 1",
                 i, resp_valid, resp_prod, req_ready, busy);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b ready=%b state=%0d want 0 1 0",
               resp_valid, req_ready, dbg_state);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    req_valid = 1'b1;
    req_a = 16'h0009;
    req_b = 16'h0009;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got valid=%b busy=%b ready=%b want 0 0 1",
               resp_valid, busy, req_ready);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_discard: got resp_valid=1 after abort want 0");
    end
    run_vector(16'h0004, 16'h0006);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, ep;
    int edges, guard;
    for (int n = 0; n < 200; n++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      if (n % 8 == 0) b = b >> $urandom_range(8, 16);
      exp_q.push_back(ref_mul(a, b));
      issue_and_wait(a, b, edges);
      ep = exp_q.pop_front();
      n_tests++;
      if (resp_prod !== ep || resp_zr !== (ep == 16'h0) || resp_ng !== ep[15]) begin
        n_fail++;
        $display("FAIL b2b_%0d a=%h b=%h: got prod=%h zr=%b ng=%b want %h %b %b",
                 n, a, b, resp_prod, resp_zr, resp_ng, ep, (ep == 16'h0), ep[15]);
      end
      guard = 0;
      while (resp_valid === 1'b1) begin
        resp_ready = (guard > 32) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
